// File: rtl/piso_serializer.sv
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in, serial-out converter with valid/ready load port,
//               per-bit valid strobe and last-bit marker. Define PISO_PARITY_EN
//               to append an even-parity bit after the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN);
    localparam logic [CW-1:0] c_cnt_load = CW'(FLEN - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [FLEN-1:0] r_sr;
    logic [FLEN-1:0] w_frame;
    logic [FLEN-1:0] w_sr_shift;
    logic [CW-1:0]   r_cnt;
    logic            w_cnt_zero;
    logic            w_accept;
    logic            w_head;

    // Frame is laid out so the head bit always sits at the shift-out end.
`ifdef PISO_PARITY_EN
    generate
        if (MSB_FIRST) begin : g_frame_msb
            assign w_frame = {load_data, ^load_data};
        end else begin : g_frame_lsb
            assign w_frame = {^load_data, load_data};
        end
    endgenerate
`else
    assign w_frame = load_data;
`endif

    generate
        if (MSB_FIRST) begin : g_shift_msb
            assign w_sr_shift = {r_sr[FLEN-2:0], 1'b0};
            assign w_head     = r_sr[FLEN-1];
        end else begin : g_shift_lsb
            assign w_sr_shift = {1'b0, r_sr[FLEN-1:1]};
            assign w_head     = r_sr[0];
        end
    endgenerate

    assign w_cnt_zero = (r_cnt == '0);
    assign load_ready = reset && ((r_state == S_IDLE) || w_cnt_zero);
    assign w_accept   = load_valid && load_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_cnt_zero && !w_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reload at the last bit keeps back-to-back frames gap-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sr  <= w_frame;
            r_cnt <= c_cnt_load;
        end else if (r_state == S_SHIFT) begin
            r_sr <= w_sr_shift;
            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign dout_valid = (r_state == S_SHIFT);
    assign busy       = (r_state == S_SHIFT);
    assign dout       = dout_valid && w_head;
    assign dout_last  = dout_valid && w_cnt_zero;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: MSB-first and LSB-first instances share stimulus;
// a frame-level model fills per-instance queues that a negedge monitor drains.
`default_nettype none

module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;

    logic rdy_m, dout_m, dv_m, dl_m, busy_m;
    logic rdy_l, dout_l, dv_l, dl_l, busy_l;

    logic [1:0] q_m[$];   // {bit, last}
    logic [1:0] q_l[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_m), .dout(dout_m), .dout_valid(dv_m), .dout_last(dl_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_l), .dout(dout_l), .dout_valid(dv_l), .dout_last(dl_l), .busy(busy_l)
    );

    // Expected frame as a bit list: data bits in transmit order, then parity if enabled.
    task automatic push_frame(input bit to_m, input bit to_l, input logic [W-1:0] d);
        logic bm, bl, last;
        for (int i = 0; i < FLEN; i++) begin
            bm   = (i < W) ? d[W-1-i] : ^d;
            bl   = (i < W) ? d[i]     : ^d;
            last = (i == FLEN - 1);
            if (to_m) q_m.push_back({bm, last});
            if (to_l) q_l.push_back({bl, last});
        end
    endtask

    // Called at posedge+1; returns at next posedge+1. Acceptance seen at the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, output bit acc);
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        acc = reset && v && (rdy_m || rdy_l);
        if (reset && v) push_frame(rdy_m, rdy_l, d);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), a);
    endtask

    task automatic send(input logic [W-1:0] d);
        bit a;
        cycle(1'b1, d, a);
    endtask

    task automatic assert_reset(input int n);
        bit a;
        reset = 1'b0;
        q_m.delete();
        q_l.delete();
        for (int i = 0; i < n; i++) cycle(1'b1, W'($urandom), a);
        reset = 1'b1;
    endtask

    // Expected vector order: {load_ready, dout, dout_valid, dout_last, busy}
    task automatic check_dut(input int id, input logic rdy, input logic d, input logic dv,
                             input logic dl, input logic bsy);
        int         n;
        logic [1:0] e;
        logic [4:0] exp_v, act_v;
        n     = (id == 0) ? q_m.size() : q_l.size();
        act_v = {rdy, d, dv, dl, bsy};
        if (!reset) begin
            exp_v = 5'b00000;
        end else if (n == 0) begin
            exp_v = 5'b10000;
        end else begin
            if (id == 0) e = q_m.pop_front();
            else         e = q_l.pop_front();
            exp_v = {(n == 1), e[1], 1'b1, e[0], 1'b1};
        end
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t {ready,dout,valid,last,busy} actual=%b expected=%b",
                     (id == 0) ? "msb_first" : "lsb_first", $time, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, rdy_m, dout_m, dv_m, dl_m, busy_m);
        check_dut(1, rdy_l, dout_l, dv_l, dl_l, busy_l);
    end

    initial begin
        bit acc;
        int guard;

        // Reset held with load_valid high: nothing may be accepted.
        reset      = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3);

        send(8'hA5);
        idle(FLEN + 2);
        send(8'h01);
        idle(FLEN + 2);
        send(8'h07);
        idle(FLEN + 2);

        // Back-to-back: hold the second word until it is taken.
        send(8'hFF);
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 4 * FLEN) begin
            cycle(1'b1, 8'h00, acc);
            guard++;
        end
        checks++;
        if (!acc || guard != FLEN) begin
            errors++;
            $display("FAIL back_to_back_accept_cycle actual=%0d expected=%0d", guard, FLEN);
        end
        idle(FLEN + 2);

        // Reset in cycle 4 of a frame, then a clean frame.
        send(8'hC3);
        idle(3);
        assert_reset(2);
        send(8'h3C);
        idle(FLEN + 2);

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                assert_reset($urandom_range(1, 2));
            end else begin
                cycle(($urandom_range(0, 3) != 0), W'($urandom), acc);
            end
        end
        idle(FLEN + 3);

        checks++;
        if (q_m.size() != 0 || q_l.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d expected=0/0", q_m.size(), q_l.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
